cue_power_ctrl: RTL
===================

Name: cue_power_ctrl

Overview:
Shot-power sequencer for the cue. It ramps a power value up and down once per frame while the shoot key is held, and drives that value to the power-bar renderer. On key release it fires a single-cycle shot pulse carrying the latched power. It then holds off further shots until the balls have come to rest.

Parameters:
MAX_POWER, 120, saturation value of power; equals the full bar length in pixels.
STEP, 2, power change per ramp step.
FRAMES_PER_STEP, 1, number of frame ticks per ramp step (minimum 1).
SETTLE_FRAMES, 4, consecutive frame ticks with balls still required before re-arming (minimum 1).
PW, 7, power width in bits; must hold MAX_POWER.

Ports:
clk  in  1  system clock (VGA pixel clock domain).
resetN  in  1  asynchronous active-low reset.
startOfFrame  in  1  one-cycle pulse per video frame; the ramp and settle timebase.
keyHold  in  1  shoot key level, asynchronous to clk.
ballsMoving  in  1  high while any ball velocity is non-zero.
power  out  PW  live power value for the bar renderer; unsigned, 0..MAX_POWER.
shotPulse  out  1  one-cycle strobe that launches the cue ball.
shotPower  out  PW  power latched at fire; stable from the shotPulse cycle until the next fire.
ready  out  1  high when a new shot may start.

Behaviour:
- Reset values: every output is 0, state is IDLE, all counters are 0.
- Single clock and asynchronous active-low reset (clk, resetN). Reset mid-operation aborts any charge with no shotPulse.
- keyHold passes through a 2-flop synchroniser, giving keyS. keyRise is keyS high while its previous value was low.
- tick = startOfFrame AND (prescaler == FRAMES_PER_STEP-1).
  - The prescaler counts startOfFrame pulses and wraps to 0 on tick.
  - The prescaler is cleared when entering either CHARGE state.
- All outputs are registered.
- States: IDLE, CHARGE_UP, CHARGE_DOWN, FIRE, WAIT_STOP.
- IDLE:
  - power = 0.
  - ready = !ballsMoving.
  - keyRise AND !ballsMoving leads to CHARGE_UP.
  - keyRise while ballsMoving is ignored. It is not queued, and a key still held afterwards does not start a charge.
- CHARGE_UP, on tick:
  - If power+STEP >= MAX_POWER, power = MAX_POWER and go to CHARGE_DOWN.
  - Otherwise power += STEP.
  - Width rule: compute the sum in PW+1 bits; no wrap is allowed.
- CHARGE_DOWN, on tick:
  - If power <= STEP, power = 0 and go to CHARGE_UP.
  - Otherwise power -= STEP.
  - No underflow is allowed.
- Release in either CHARGE state (keyS low):
  - Release has priority over a tick in the same cycle; power is not updated that cycle.
  - If power == 0, return to IDLE with no shot (cancel).
  - Otherwise go to FIRE.
- FIRE: exactly one cycle.
  - shotPulse = 1 and shotPower = power, both in this cycle.
  - Next state is WAIT_STOP, with power cleared to 0.
- WAIT_STOP:
  - ready = 0.
  - settleCnt clears whenever ballsMoving is high.
  - On a tick with ballsMoving low, settleCnt increments.
  - When settleCnt reaches SETTLE_FRAMES-1 on a qualifying tick, clear settleCnt and go to IDLE.
  - This tolerates ballsMoving rising a few cycles after the shotPulse.
- Latency:
  - Key edge to CHARGE_UP entry: 3 clk cycles (2-flop sync plus state register).
  - Release to shotPulse: 3 clk cycles.
- Power is always within 0..MAX_POWER. MAX_POWER need not be a multiple of STEP; saturation clamps it.

Decomposition:
- Package cue_pkg holds:
  - the state enum type;
  - default constants MAX_POWER and STEP, shared with the bar renderer so bar length and power range agree.
- One natural sub-module is key_sync_edge: the 2-flop synchroniser plus rising-edge detect, reused for the other game keys.
- The FSM, prescaler and settle counter stay in cue_power_ctrl.

Test Plan:
1. Reset with all defaults, ballsMoving=0: every output is 0 and ready=1 one cycle after resetN rises.
2. Press, 10 ticks, release: power=20 before release. shotPulse is high for exactly 1 cycle with shotPower=20, then power=0 and ready=0.
3. Hold for 62 ticks: power reaches 120 at tick 60, is 118 at tick 61 and 116 at tick 62. Release then fires with shotPower=116.
4. Press and release before any tick: no shotPulse, return to IDLE, ready stays 1.
5. After fire, ballsMoving high for 20 ticks then low: ready returns 1 exactly 4 ticks after the fall. A keyRise while ballsMoving=1 is ignored.
6. resetN asserted mid-CHARGE_UP at power=40: power=0 and state IDLE immediately, with no shotPulse after release.

Source files
------------

// File: rtl/cue_pkg.sv
// Shared definitions for the cue shot-power sequencer and the power-bar renderer.
// Holds the sequencer state type and the default power range so that the bar
// length and the power range always agree.
package cue_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_CHARGE_UP   = 3'd1,
    ST_CHARGE_DOWN = 3'd2,
    ST_FIRE        = 3'd3,
    ST_WAIT_STOP   = 3'd4
  } cue_state_e;

  // Full bar length in pixels doubles as the saturation power.
  localparam int unsigned MAX_POWER = 120;
  localparam int unsigned STEP      = 2;

endpackage

// File: rtl/key_sync_edge.sv
// Two-flop synchroniser for an asynchronous key level plus rising-edge detect.
// Ports: clk_i, rst_ni (async active-low), key_i (async level),
//        key_s_o (synchronised level), key_rise_o (one-cycle pulse on 0->1 of key_s_o).
module key_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_i,
  output logic key_s_o,
  output logic key_rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= key_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign key_s_o    = sync_q;
  assign key_rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/cue_power_ctrl.sv
// Cue shot-power sequencer: ramps power up/down per frame tick while the shoot key
// is held, fires a one-cycle shot carrying the latched power on release, then waits
// for the balls to settle before re-arming.
// Ports: clk, resetN (async active-low), startOfFrame, keyHold (async), ballsMoving;
//        power (live bar value), shotPulse, shotPower (latched at fire), ready.
module cue_power_ctrl #(
  parameter int unsigned MAX_POWER       = cue_pkg::MAX_POWER,
  parameter int unsigned STEP            = cue_pkg::STEP,
  parameter int unsigned FRAMES_PER_STEP = 1,
  parameter int unsigned SETTLE_FRAMES   = 4,
  parameter int          PW              = 7
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          startOfFrame,
  input  logic          keyHold,
  input  logic          ballsMoving,
  output logic [PW-1:0] power,
  output logic          shotPulse,
  output logic [PW-1:0] shotPower,
  output logic          ready
);

  import cue_pkg::*;

  // Counter widths are kept at least 1 bit so the minimum parameter values work.
  localparam int PSW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam int SCW = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;

  localparam logic [PSW-1:0] PRESC_LAST  = PSW'(FRAMES_PER_STEP - 1);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_FRAMES - 1);
  localparam logic [PW:0]    STEP_W      = (PW+1)'(STEP);
  localparam logic [PW:0]    MAX_W       = (PW+1)'(MAX_POWER);
  localparam logic [PW-1:0]  STEP_P      = PW'(STEP);
  localparam logic [PW-1:0]  MAX_P       = PW'(MAX_POWER);

  cue_state_e     state_q, state_d;
  logic [PW-1:0]  power_q, power_d;
  logic [PW-1:0]  shot_power_q, shot_power_d;
  logic           shot_pulse_q, shot_pulse_d;
  logic           ready_q, ready_d;
  logic [PSW-1:0] presc_q, presc_d;
  logic [SCW-1:0] settle_q, settle_d;
  logic [PW:0]    sum_up;
  logic           key_s;
  logic           key_rise;
  logic           tick;
  logic           in_charge_q;
  logic           in_charge_d;

  key_sync_edge u_key_sync (
    .clk_i      (clk),
    .rst_ni     (resetN),
    .key_i      (keyHold),
    .key_s_o    (key_s),
    .key_rise_o (key_rise)
  );

  assign tick        = startOfFrame && (presc_q == PRESC_LAST);
  assign in_charge_q = (state_q == ST_CHARGE_UP) || (state_q == ST_CHARGE_DOWN);
  assign in_charge_d = (state_d == ST_CHARGE_UP) || (state_d == ST_CHARGE_DOWN);

  // Prescaler restarts on charge entry so the first step is a full period away.
  always_comb begin
    presc_d = presc_q;
    if (in_charge_d && !in_charge_q) begin
      presc_d = '0;
    end else if (startOfFrame) begin
      presc_d = tick ? '0 : presc_q + PSW'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    power_d      = power_q;
    shot_pulse_d = 1'b0;
    shot_power_d = shot_power_q;
    settle_d     = settle_q;
    // One extra bit so the saturation compare can never see a wrapped sum.
    sum_up       = {1'b0, power_q} + STEP_W;

    unique case (state_q)
      ST_IDLE: begin
        power_d  = '0;
        settle_d = '0;
        // A press while balls roll is dropped, not queued.
        if (key_rise && !ballsMoving) begin
          state_d = ST_CHARGE_UP;
        end
      end

      ST_CHARGE_UP, ST_CHARGE_DOWN: begin
        // Release wins over a coincident tick; power is frozen that cycle.
        if (!key_s) begin
          if (power_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            state_d      = ST_FIRE;
            shot_pulse_d = 1'b1;
            shot_power_d = power_q;
          end
        end else if (tick) begin
          if (state_q == ST_CHARGE_UP) begin
            if (sum_up >= MAX_W) begin
              power_d = MAX_P;
              state_d = ST_CHARGE_DOWN;
            end else begin
              power_d = sum_up[PW-1:0];
            end
          end else begin
            if (power_q <= STEP_P) begin
              power_d = '0;
              state_d = ST_CHARGE_UP;
            end else begin
              power_d = power_q - STEP_P;
            end
          end
        end
      end

      ST_FIRE: begin
        state_d = ST_WAIT_STOP;
        power_d = '0;
      end

      ST_WAIT_STOP: begin
        if (ballsMoving) begin
          settle_d = '0;
        end else if (tick) begin
          if (settle_q == SETTLE_LAST) begin
            settle_d = '0;
            state_d  = ST_IDLE;
          end else begin
            settle_d = settle_q + SCW'(1);
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        power_d = '0;
      end
    endcase

    ready_d = (state_d == ST_IDLE) && !ballsMoving;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      power_q      <= '0;
      shot_pulse_q <= 1'b0;
      shot_power_q <= '0;
      ready_q      <= 1'b0;
      presc_q      <= '0;
      settle_q     <= '0;
    end else begin
      state_q      <= state_d;
      power_q      <= power_d;
      shot_pulse_q <= shot_pulse_d;
      shot_power_q <= shot_power_d;
      ready_q      <= ready_d;
      presc_q      <= presc_d;
      settle_q     <= settle_d;
    end
  end

  assign power     = power_q;
  assign shotPulse = shot_pulse_q;
  assign shotPower = shot_power_q;
  assign ready     = ready_q;

endmodule
